// File: rtl/bp_profiler_pkg.sv
// Shared profiler definitions: stall-counter address offsets and read-request format.
package bp_profiler_pkg;

  // Non-reason counters sit directly above the reason counters; add these to num_reasons_p.
  localparam int stall_ctr_instret_gp = 0;
  localparam int stall_ctr_cycle_gp   = 1;
  localparam int stall_ctr_unattr_gp  = 2;
  localparam int stall_ctr_extra_gp   = 3;

  localparam int stall_ctr_addr_width_gp = 16;

  typedef struct packed {
    logic [stall_ctr_addr_width_gp-1:0] addr;
  } bp_stall_rd_req_s;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_stall_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module bp_stall_sat_counter #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else if (clear_i) begin
      count_r <= '0;
    end else if (up_i && (count_r != '1)) begin
      count_r <= count_r + 1'b1;
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/bp_stall_counter_bank.sv
// Per-reason stall counters plus instret/cycle/unattributed counters, with a
// one-entry handshaked read port for the host CSR bridge.
module bp_stall_counter_bank
  import bp_profiler_pkg::*;
#(
  parameter  int num_reasons_p = 64,
  parameter  int ctr_width_p   = 32,
  localparam int lg_reasons_lp = safe_clog2(num_reasons_p),
  localparam int addr_width_lp = safe_clog2(num_reasons_p + 3)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     en_i,
  input  logic                     instret_i,
  input  logic                     stall_v_i,
  input  logic [lg_reasons_lp-1:0] stall_reason_i,
  input  logic                     clear_i,
  input  logic                     rd_v_i,
  input  logic [addr_width_lp-1:0] rd_addr_i,
  output logic                     rd_ready_o,
  output logic                     rd_data_v_o,
  output logic [ctr_width_p-1:0]   rd_data_o,
  input  logic                     rd_yumi_i
);

  localparam int num_ctrs_lp    = num_reasons_p + stall_ctr_extra_gp;
  localparam int instret_idx_lp = num_reasons_p + stall_ctr_instret_gp;
  localparam int cycle_idx_lp   = num_reasons_p + stall_ctr_cycle_gp;
  localparam int unattr_idx_lp  = num_reasons_p + stall_ctr_unattr_gp;

  localparam logic [lg_reasons_lp:0] reasons_lim_lp = (lg_reasons_lp + 1)'(num_reasons_p);

  logic                   reason_in_range;
  logic                   stall_hit;
  logic [num_ctrs_lp-1:0] ctr_up;
  logic [ctr_width_p-1:0] ctr_r [num_ctrs_lp];

  assign reason_in_range = ({1'b0, stall_reason_i} < reasons_lim_lp);
  // Retirement takes precedence; a stall reason only counts on non-retiring cycles.
  assign stall_hit       = en_i & ~instret_i & stall_v_i & reason_in_range;

  for (genvar i = 0; i < num_reasons_p; i++) begin : g_reason_up
    assign ctr_up[i] = stall_hit & (stall_reason_i == lg_reasons_lp'(i));
  end

  assign ctr_up[instret_idx_lp] = en_i & instret_i;
  assign ctr_up[cycle_idx_lp]   = en_i;
  assign ctr_up[unattr_idx_lp]  = en_i & ~instret_i & ~(stall_v_i & reason_in_range);

  for (genvar i = 0; i < num_ctrs_lp; i++) begin : g_ctr
    bp_stall_sat_counter #(
      .width_p(ctr_width_p)
    ) u_ctr (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .clear_i  (clear_i),
      .up_i     (ctr_up[i]),
      .count_o  (ctr_r[i])
    );
  end

  bp_stall_rd_req_s       rd_req;
  logic [ctr_width_p-1:0] rd_mux_data;
  logic                   rd_accept;
  logic                   rd_data_v_r;
  logic [ctr_width_p-1:0] rd_data_r;

  assign rd_req.addr = stall_ctr_addr_width_gp'(rd_addr_i);

  // Sampled from the counter registers, so a read sees the value before this cycle's update.
  always_comb begin
    rd_mux_data = '0;
    for (int i = 0; i < num_ctrs_lp; i++) begin
      if (rd_req.addr == stall_ctr_addr_width_gp'(i)) begin
        rd_mux_data = ctr_r[i];
      end
    end
  end

  assign rd_ready_o = ~rd_data_v_r | rd_yumi_i;
  assign rd_accept  = rd_v_i & rd_ready_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_data_v_r <= 1'b0;
    end else if (rd_accept) begin
      rd_data_v_r <= 1'b1;
    end else if (rd_yumi_i) begin
      rd_data_v_r <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_data_r <= '0;
    end else if (rd_accept) begin
      rd_data_r <= rd_mux_data;
    end
  end

  assign rd_data_v_o = rd_data_v_r;
  assign rd_data_o   = rd_data_r;

endmodule
